lm32_multiplier_tracker: RTL and testbench

- Tracks multiply instructions through the X, M and W stages, in lock-step with the DSP-based pipelined multiplier.
- The multiplier captures operands in X on ~stall_x and the product in M on ~stall_m. Its output register is always enabled, so the 32-bit result is valid only in the single cycle after M advances.
- This block produces the D-stage interlock and bypass controls for multiply results.
- It owns the multiply write-back request to the register file, with a one-entry hold buffer for when the write port is not granted.

---
 rtl/lm32_multiplier_tracker.sv | 139 +++++++++++++
 tb/tb_lm32_multiplier_tracker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lm32_multiplier_tracker.sv
// Multiply-result tracker for the X/M/W pipeline.
// Follows each multiply through the DSP multiplier stages and produces the
// D-stage interlock and bypass controls for it. It also owns the register-file
// write-back request, with a one-entry hold buffer for when the write port is
// not granted.
module lm32_multiplier_tracker (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_x,
  input  logic        stall_m,
  input  logic        kill_x,
  input  logic        kill_m,
  input  logic        mul_x,
  input  logic [4:0]  write_idx_x,
  input  logic [4:0]  read_idx_0_d,
  input  logic [4:0]  read_idx_1_d,
  input  logic        read_en_0_d,
  input  logic        read_en_1_d,
  input  logic [31:0] mul_result,
  input  logic        wb_ready,
  output logic        stall_req_d,
  output logic        bypass_0_d,
  output logic        bypass_1_d,
  output logic        hold_busy,
  output logic        mul_wb_valid,
  output logic [4:0]  mul_wb_idx,
  output logic [31:0] mul_wb_data
);

  // M slot: the multiply whose operands are currently in the multiplier.
  logic        r_m_valid;
  logic [4:0]  r_m_idx;
  // W slot: one-cycle pulse, aligned with the multiplier output register.
  logic        r_w_valid;
  logic [4:0]  r_w_idx;
  // Hold buffer: a result that was not accepted by the write port.
  logic        r_h_valid;
  logic [4:0]  r_h_idx;
  logic [31:0] r_h_data;

  logic        w_wb_valid;
  logic [4:0]  w_wb_idx;
  logic [31:0] w_wb_data;
  logic        w_stall;
  logic [1:0][4:0] w_rd_idx;
  logic [1:0]  w_rd_en;
  logic [1:0]  w_hazard;
  logic [1:0]  w_bypass;

  assign w_rd_idx[0] = read_idx_0_d;
  assign w_rd_idx[1] = read_idx_1_d;
  assign w_rd_en[0]  = read_en_0_d;
  assign w_rd_en[1]  = read_en_1_d;

  // M slot follows the multiplier input registers (CEA/CEB = ~stall_x).
  // When X stalls but M advances, a bubble enters M. A kill while M is
  // stalled squashes the held multiply.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m_valid <= 1'b0;
      r_m_idx   <= 5'd0;
    end else if (!stall_x) begin
      r_m_valid <= mul_x & ~kill_x;
      r_m_idx   <= write_idx_x;
    end else if (!stall_m || kill_m) begin
      r_m_valid <= 1'b0;
    end
  end

  // W slot is set only when M actually advances, so it is valid exactly in the
  // cycle the always-enabled output register holds this multiply's product.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_w_valid <= 1'b0;
      r_w_idx   <= 5'd0;
    end else begin
      r_w_valid <= r_m_valid & ~kill_m & ~stall_m;
      r_w_idx   <= r_m_idx;
    end
  end

  // Hold buffer captures a W result refused by the write port and keeps it
  // until the port is granted. An existing entry always wins over a new one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_h_valid <= 1'b0;
      r_h_idx   <= 5'd0;
      r_h_data  <= 32'd0;
    end else if (r_h_valid) begin
      if (wb_ready) begin
        r_h_valid <= 1'b0;
      end
    end else if (r_w_valid && !wb_ready) begin
      r_h_valid <= 1'b1;
      r_h_idx   <= r_w_idx;
      r_h_data  <= mul_result;
    end
  end

  // Write-back source selection: the held result takes priority over the live
  // W result, and index/data read as zero when nothing is being written.
  always_comb begin
    w_wb_valid = 1'b0;
    w_wb_idx   = 5'd0;
    w_wb_data  = 32'd0;
    if (r_h_valid) begin
      w_wb_valid = 1'b1;
      w_wb_idx   = r_h_idx;
      w_wb_data  = r_h_data;
    end else if (r_w_valid) begin
      w_wb_valid = 1'b1;
      w_wb_idx   = r_w_idx;
      w_wb_data  = mul_result;
    end
  end

  // Per-source interlock and bypass. A source stalls while its producer is in
  // X or M. Register 0 is hard-wired, so it never matches.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign w_hazard[gi] = w_rd_en[gi] && (w_rd_idx[gi] != 5'd0) &&
                            ((mul_x && !kill_x && (w_rd_idx[gi] == write_idx_x)) ||
                             (r_m_valid && (w_rd_idx[gi] == r_m_idx)));
      assign w_bypass[gi] = w_rd_en[gi] && w_wb_valid && (w_rd_idx[gi] == w_wb_idx) &&
                            (w_rd_idx[gi] != 5'd0) && !w_stall;
    end
  endgenerate

  assign w_stall      = |w_hazard;
  assign stall_req_d  = w_stall;
  assign bypass_0_d   = w_bypass[0];
  assign bypass_1_d   = w_bypass[1];
  assign hold_busy    = r_h_valid;
  assign mul_wb_valid = w_wb_valid;
  assign mul_wb_idx   = w_wb_idx;
  assign mul_wb_data  = w_wb_data;

endmodule

// File: tb/tb_lm32_multiplier_tracker.sv
// Bench for lm32_multiplier_tracker: directed scenarios followed by random
// traffic. The reference model tracks each multiply as a record with a stage
// tag. The expected control outputs and write-backs go into queues that a
// separate monitor drains.
module tb_lm32_multiplier_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_x = 1'b0, stall_m = 1'b0, kill_x = 1'b0, kill_m = 1'b0, mul_x = 1'b0;
  logic [4:0]  write_idx_x = '0, read_idx_0_d = '0, read_idx_1_d = '0;
  logic        read_en_0_d = 1'b0, read_en_1_d = 1'b0;
  logic [31:0] mul_result = '0;
  logic        wb_ready = 1'b1;
  logic        stall_req_d, bypass_0_d, bypass_1_d, hold_busy, mul_wb_valid;
  logic [4:0]  mul_wb_idx;
  logic [31:0] mul_wb_data;

  always #5 clk_i = ~clk_i;

  lm32_multiplier_tracker dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_x(stall_x), .stall_m(stall_m),
    .kill_x(kill_x), .kill_m(kill_m), .mul_x(mul_x), .write_idx_x(write_idx_x),
    .read_idx_0_d(read_idx_0_d), .read_idx_1_d(read_idx_1_d),
    .read_en_0_d(read_en_0_d), .read_en_1_d(read_en_1_d),
    .mul_result(mul_result), .wb_ready(wb_ready),
    .stall_req_d(stall_req_d), .bypass_0_d(bypass_0_d), .bypass_1_d(bypass_1_d),
    .hold_busy(hold_busy), .mul_wb_valid(mul_wb_valid),
    .mul_wb_idx(mul_wb_idx), .mul_wb_data(mul_wb_data)
  );

  // stage: 1 = operands in multiplier (M), 2 = product on output (W), 3 = held
  typedef struct {
    int          stage;
    logic [4:0]  idx;
    logic [31:0] data;
  } op_t;

  typedef struct packed {
    logic stall;
    logic byp0;
    logic byp1;
    logic hold;
    logic wbv;
  } ctl_t;

  op_t         ops[$];
  op_t         wbq[$];
  ctl_t        ctlq[$];
  logic [31:0] dataq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit in_m(input logic [4:0] r);
    bit hit;
    hit = 1'b0;
    foreach (ops[i]) if (ops[i].stage == 1 && ops[i].idx == r) hit = 1'b1;
    return hit;
  endfunction

  // Monitor: one expected control record per checked cycle; write-back
  // contents compared against the oldest outstanding result.
  initial begin
    forever begin
      @(negedge clk_i);
      if (ctlq.size() > 0) begin
        ctl_t e;
        e = ctlq.pop_front();
        check1("stall_req_d", 32'(stall_req_d), 32'(e.stall));
        check1("bypass_0_d", 32'(bypass_0_d), 32'(e.byp0));
        check1("bypass_1_d", 32'(bypass_1_d), 32'(e.byp1));
        check1("hold_busy", 32'(hold_busy), 32'(e.hold));
        check1("mul_wb_valid", 32'(mul_wb_valid), 32'(e.wbv));
        if (mul_wb_valid) begin
          if (wbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected cycle %0d: got idx %0d data %h expected no write-back",
                     cyc, mul_wb_idx, mul_wb_data);
          end else begin
            check1("mul_wb_idx", 32'(mul_wb_idx), 32'(wbq[0].idx));
            check1("mul_wb_data", mul_wb_data, wbq[0].data);
            if (wb_ready) wbq.delete(0);
          end
        end else begin
          check1("wb_idx_idle", 32'(mul_wb_idx), 32'd0);
          check1("wb_data_idle", mul_wb_data, 32'd0);
        end
      end
    end
  end

  // One clock of stimulus plus the model's expectation and state update.
  // The core's obligation to stall M while a result is (or is about to be)
  // held is applied here, as is stall_m implying stall_x.
  task automatic step(input logic mx, input logic [4:0] wi, input logic kx, input logic km,
                      input logic sx, input logic sm, input logic [4:0] r0, input logic e0,
                      input logic [4:0] r1, input logic e1, input logic rdy, input logic rst,
                      input bit chk);
    bit          has2, has3, wbv, hz0, hz1, st;
    logic [4:0]  wbi;
    logic [31:0] mres;
    ctl_t        e;
    op_t         nxt[$];
    op_t         o;
    has2 = 1'b0; has3 = 1'b0; wbv = 1'b0; wbi = '0; mres = $urandom;
    foreach (ops[i]) begin
      if (ops[i].stage == 2) begin
        has2 = 1'b1;
        mres = ops[i].data;
        if (!has3) begin wbv = 1'b1; wbi = ops[i].idx; end
      end
      if (ops[i].stage == 3) begin has3 = 1'b1; wbv = 1'b1; wbi = ops[i].idx; end
    end
    if (has3 || (has2 && !rdy)) sm = 1'b1;
    if (sm) sx = 1'b1;

    @(posedge clk_i);
    #1;
    rst_i = rst; mul_x = mx; write_idx_x = wi; kill_x = kx; kill_m = km;
    stall_x = sx; stall_m = sm; read_idx_0_d = r0; read_en_0_d = e0;
    read_idx_1_d = r1; read_en_1_d = e1; wb_ready = rdy; mul_result = mres;

    hz0 = e0 && (r0 != 5'd0) && ((mx && !kx && r0 == wi) || in_m(r0));
    hz1 = e1 && (r1 != 5'd0) && ((mx && !kx && r1 == wi) || in_m(r1));
    st = hz0 || hz1;
    e.stall = st;
    e.byp0  = e0 && wbv && (r0 == wbi) && (r0 != 5'd0) && !st;
    e.byp1  = e1 && wbv && (r1 == wbi) && (r1 != 5'd0) && !st;
    e.hold  = has3;
    e.wbv   = wbv;
    if (chk) ctlq.push_back(e);

    @(negedge clk_i);
    #1;
    cyc++;
    if (rst) begin
      ops.delete();
      wbq.delete();
    end else begin
      foreach (ops[i]) begin
        o = ops[i];
        if (o.stage >= 2) begin
          if (!rdy) begin o.stage = 3; nxt.push_back(o); end
        end else if (!km) begin
          if (!sm) begin
            o.stage = 2;
            o.data = (dataq.size() > 0) ? dataq.pop_front() : $urandom;
            nxt.push_back(o);
            wbq.push_back(o);
          end else begin
            nxt.push_back(o);
          end
        end
      end
      if (!sx && mx && !kx) begin
        o.stage = 1; o.idx = wi; o.data = '0;
        nxt.push_back(o);
      end
      ops = nxt;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
  endtask

  initial begin
    // Reset: state is unknown during the first reset cycle.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(1);

    // Back-to-back multiplies, no stalls.
    dataq.push_back(32'h12345678);
    dataq.push_back(32'h9ABCDEF0);
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(3);

    // Dependent read of r5: two stall cycles, then bypass in W.
    dataq.push_back(32'h0000ABCD);
    step(1, 5, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0, 1);
    idle(1);

    // Stall in M for three cycles, with r6 read on source 1.
    step(1, 6, 0, 0, 0, 0, 0, 0, 6, 1, 1, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 1, 0, 0, 6, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 1, 0, 1);
    idle(1);

    // kill_m on r7 in M, then kill_x with a multiply in X.
    step(1, 7, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0, 7, 1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 1);
    step(1, 8, 1, 0, 0, 0, 8, 1, 8, 1, 1, 0, 1);
    idle(3);

    // Write port busy for two cycles at the W pulse of r9.
    dataq.push_back(32'hDEADBEEF);
    step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 1, 0, 1);
    idle(2);

    // Reset with a multiply in M and the hold buffer full.
    dataq.push_back(32'h11112222);
    step(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 11, 1, 10, 1, 0, 1, 1);
    idle(3);

    // Random traffic over a small register range so matches are frequent.
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0), 1);
    end
    idle(4);

    @(negedge clk_i);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
